hctrl_responder: RTL and testbench
==================================

Name: hctrl_responder

Overview:
- Device-side end of the hand-controller serial link; emulates two chained 74HC165 parallel-in/serial-out shift registers.
- Host drives hctrl_clk and hctrl_load_n; the block returns controller state serially on hctrl_data.
- Sits between the local button/gamepad-mapping logic, which supplies two 8-bit active-low button bytes, and the external connector pins. All link inputs are asynchronous to clk.

Parameters:
- SYNC_STAGES, 2, synchronizer flip-flop depth on hctrl_clk_in and hctrl_load_n_in (min 2).
- TIMEOUT_W, 20, width of the host-activity timeout counter; timeout = 2^TIMEOUT_W − 1 clk cycles without a load.
- FILTER_LEN, 4, consecutive equal samples required before an input change is accepted (HCTRL_GLITCH_FILTER_EN only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hctrl_clk_in  in  1  host shift clock, asynchronous
- hctrl_load_n_in  in  1  host parallel-load strobe, active-low, asynchronous
- hctrl_data  out  1  serial data to host
- hctrl1_data  in  8  controller 1 buttons, active-low, idle 8'hFF
- hctrl2_data  in  8  controller 2 buttons, active-low, idle 8'hFF
- frame_strobe  out  1  one-cycle pulse when a load ends (load_n deasserts)
- host_active  out  1  high while loads arrive within the timeout window

Behaviour:
- Reset (async assert, sync release): shreg = 16'hFFFF; hctrl_data = 1; frame_strobe = 0; host_active = 0; timeout counter = 0; shift count = 0.
- Synchronizer reset values: clk chain 0, load_n chain 1. No spurious edge is produced on reset release.
- Each input passes through SYNC_STAGES flops, then one edge-detect flop. Edges are detected only on synchronized values.
- Load, while synced load_n = 0:
  - shreg <= {hctrl2_data, hctrl1_data} every cycle (transparent, like a real 165).
  - Shift count cleared; clock edges ignored.
  - Load has priority over a simultaneous clock rising edge.
- Shift, on a synced hctrl_clk rising edge while synced load_n = 1:
  - shreg <= {shreg[14:0], 1'b1} (serial-in tied high).
  - Shift count increments, saturating at 16.
  - Falling edges are ignored.
- Output: hctrl_data = shreg[15], registered.
  - Bit order: hctrl2_data[7] first, hctrl1_data[0] sixteenth. After 16 shifts, output stays 1 until the next load.
- Latency: pin edge to hctrl_data change = SYNC_STAGES + 2 clk cycles.
  - Host high and low phases must each be ≥ SYNC_STAGES + 3 cycles, plus FILTER_LEN when filtering is enabled.
  - Narrower pulses may be missed; no other failure mode.
- frame_strobe: one cycle on a synced load_n rising edge.
- Timeout counter:
  - Cleared on frame_strobe; otherwise increments, saturating at all-ones.
  - host_active = 1 after any frame_strobe; host_active = 0 when the counter reaches all-ones.
  - host_active is status only; it never gates shifting.
- Mid-frame changes to hctrl1_data / hctrl2_data have no effect until the next load.
- Reset mid-frame aborts the frame: output returns to 1 immediately (async).

Optional Feature:
- Macro: HCTRL_GLITCH_FILTER_EN.
- Defined: after synchronization, each input passes through a FILTER_LEN-sample stability filter. The filtered value updates only after FILTER_LEN consecutive identical samples. Filter reset values match the synchronizer reset values. Latency grows by FILTER_LEN cycles.
- Undefined: synchronized value feeds edge detection directly; FILTER_LEN is unused.

Decomposition:
- Package hctrl_pkg:
  - HCTRL_BITS = 16
  - HCTRL_IDLE = 16'hFFFF
  - HCTRL_BTN_IDLE = 8'hFF
  - bit-order helper constant (index of first transmitted bit = 15)
- Sub-module hctrl_in_sync: synchronizer, optional filter and rise/fall edge outputs. Instantiated twice, with reset value as a parameter.

Test Plan:
- Reset released, no host activity → hctrl_data = 1, host_active = 0, no frame_strobe for 100 cycles.
- hctrl2 = 8'hA5, hctrl1 = 8'h3C; load pulse of 16 cycles, then 16 clock pulses with 256-cycle period → bits sampled at host falling edges = 16'hA53C MSB first; pulses 17–20 read 1.
- Change hctrl1 to 8'h00 mid-frame after bit 4 → remaining bits still from 8'h3C; next frame shows 8'h00.
- hctrl_clk rises while load_n = 0 → no shift; after load release, first bit = hctrl2[7].
- No load for 2^TIMEOUT_W cycles (TIMEOUT_W = 8 in bench) → host_active falls at cycle 255 after the last strobe; the next load end raises it on the frame_strobe cycle.
- Reset asserted after 5 shifts → hctrl_data = 1 immediately; with HCTRL_GLITCH_FILTER_EN, a 2-cycle glitch on hctrl_clk_in causes no shift.

Source files
------------

// File: rtl/hctrl_pkg.sv
// Shared constants for the hand-controller responder: frame width, idle
// patterns and the index of the first bit sent to the host.
package hctrl_pkg;

    localparam int HCTRL_BITS = 16;

    localparam logic [7:0] HCTRL_BTN_IDLE = 8'hFF;

    localparam logic [HCTRL_BITS-1:0] HCTRL_IDLE = {HCTRL_BTN_IDLE, HCTRL_BTN_IDLE};

    // The host sees shreg[15] first: hctrl2_data[7] leads the frame.
    localparam int HCTRL_FIRST_BIT = HCTRL_BITS - 1;

    localparam int HCTRL_CNT_W = $clog2(HCTRL_BITS + 1);

    localparam logic [HCTRL_CNT_W-1:0] HCTRL_CNT_MAX = HCTRL_CNT_W'(HCTRL_BITS);

    typedef logic [HCTRL_BITS-1:0] hctrl_word_t;

endpackage

// File: rtl/hctrl_in_sync.sv
// Link-input conditioner: SYNC_STAGES-deep synchronizer, optional stability
// filter (compiled in with HCTRL_GLITCH_FILTER_EN), then an edge-detect flop
// producing the cleaned level and its rise/fall pulses. RST_VAL is the idle
// level of the pin so that reset release never manufactures an edge.
module hctrl_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   clean;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
        $error("hctrl_in_sync: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    // Next state of the metastability chain: pin enters at bit 0
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    end

    // Synchronizer flops, reset to the pin's idle level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= {SYNC_STAGES{RST_VAL}};
        else          sync_q <= sync_d;
    end

`ifdef HCTRL_GLITCH_FILTER_EN
    localparam int FCNT_W = $clog2(FILTER_LEN + 1);

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Adopt a new level only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = sync_q[SYNC_STAGES-1];
            else                                   fcnt_d = fcnt_q + 1'b1;
        end
    end

    // Filter state flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= RST_VAL;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q[SYNC_STAGES-1];
`endif

    // Remember the previous cleaned level for edge detection
    always_comb begin
        prev_d = clean;
    end

    // Edge-detect flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= RST_VAL;
        else          prev_q <= prev_d;
    end

    assign level = clean;
    assign rise  = clean & ~prev_q;
    assign fall  = ~clean & prev_q;

endmodule

// File: rtl/hctrl_responder.sv
// Device end of the hand-controller link: behaves like two chained 74HC165s.
// The host's load_n/clk pins are conditioned by hctrl_in_sync; the 16-bit
// shift register is loaded transparently while load_n is low and shifts
// ones in on each host clock rise. Build option: HCTRL_GLITCH_FILTER_EN
// adds a FILTER_LEN-sample stability filter on both link inputs.
module hctrl_responder
    import hctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 20,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hctrl_clk_in,
    input  logic       hctrl_load_n_in,
    output logic       hctrl_data,
    input  logic [7:0] hctrl1_data,
    input  logic [7:0] hctrl2_data,
    output logic       frame_strobe,
    output logic       host_active
);

    logic clk_level, clk_rise, clk_fall;
    logic load_level, load_rise, load_fall;
    logic unused_edges;

    hctrl_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .RST_VAL     (1'b0)
    ) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_in  (hctrl_clk_in),
        .level   (clk_level),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    hctrl_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .RST_VAL     (1'b1)
    ) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_in  (hctrl_load_n_in),
        .level   (load_level),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    // Host clock level and falling edges, and load falling edges, carry no meaning here.
    assign unused_edges = clk_level ^ clk_fall ^ load_fall;

    hctrl_word_t                shreg_q, shreg_d;
    logic [HCTRL_CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
    logic                       hctrl_data_q, hctrl_data_d;
    logic                       frame_strobe_q, frame_strobe_d;
    logic [TIMEOUT_W-1:0]       timeout_q, timeout_d;
    logic                       host_active_q, host_active_d;

    // Shift path: load has priority and is transparent; otherwise shift ones in on clock rise
    always_comb begin
        shreg_d     = shreg_q;
        shift_cnt_d = shift_cnt_q;
        if (!load_level) begin
            shreg_d     = {hctrl2_data, hctrl1_data};
            shift_cnt_d = '0;
        end else if (clk_rise) begin
            shreg_d = {shreg_q[HCTRL_BITS-2:0], 1'b1};
            if (shift_cnt_q != HCTRL_CNT_MAX) shift_cnt_d = shift_cnt_q + 1'b1;
        end
        hctrl_data_d = shreg_q[HCTRL_FIRST_BIT];
    end

    // Frame strobe and host-activity watchdog; strobe cycle already shows host_active high
    always_comb begin
        frame_strobe_d = load_rise;
        timeout_d      = timeout_q;
        host_active_d  = host_active_q;
        if (load_rise) begin
            timeout_d     = '0;
            host_active_d = 1'b1;
        end else begin
            if (timeout_q != '1) timeout_d = timeout_q + 1'b1;
            if (timeout_d == '1) host_active_d = 1'b0;
        end
    end

    // All datapath and status registers; reset aborts any frame in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q        <= HCTRL_IDLE;
            shift_cnt_q    <= '0;
            hctrl_data_q   <= 1'b1;
            frame_strobe_q <= 1'b0;
            timeout_q      <= '0;
            host_active_q  <= 1'b0;
        end else begin
            shreg_q        <= shreg_d;
            shift_cnt_q    <= shift_cnt_d;
            hctrl_data_q   <= hctrl_data_d;
            frame_strobe_q <= frame_strobe_d;
            timeout_q      <= timeout_d;
            host_active_q  <= host_active_d;
        end
    end

    assign hctrl_data   = hctrl_data_q;
    assign frame_strobe = frame_strobe_q;
    assign host_active  = host_active_q;

endmodule

// File: tb/tb_hctrl_responder.sv
// Bench for hctrl_responder. Reference model: a load latches {hctrl2,hctrl1}
// at its end; the bit read before the k-th host clock rise is word[15-k] for
// k < 16 and 1 afterwards.
`timescale 1ns/1ps
module tb_hctrl_responder;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_W   = 8;
    localparam int FILTER_LEN  = 4;
`ifdef HCTRL_GLITCH_FILTER_EN
    localparam int MIN_HALF = SYNC_STAGES + 3 + FILTER_LEN;
`else
    localparam int MIN_HALF = SYNC_STAGES + 3;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hctrl_clk_in;
    logic       hctrl_load_n_in;
    logic       hctrl_data;
    logic [7:0] hctrl1_data;
    logic [7:0] hctrl2_data;
    logic       frame_strobe;
    logic       host_active;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_word;
    logic        rd [0:63];
    int          rd_n;

    always #5 clk = ~clk;

    hctrl_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_W   (TIMEOUT_W),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .hctrl_clk_in    (hctrl_clk_in),
        .hctrl_load_n_in (hctrl_load_n_in),
        .hctrl_data      (hctrl_data),
        .hctrl1_data     (hctrl1_data),
        .hctrl2_data     (hctrl2_data),
        .frame_strobe    (frame_strobe),
        .host_active     (host_active)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host load pulse; the model word is what the buttons show when load ends.
    task automatic host_load(input int len, output bit seen);
        hctrl_load_n_in = 1'b0;
        cyc(len);
        model_word = {hctrl2_data, hctrl1_data};
        hctrl_load_n_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_strobe === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // n host clock pulses; hctrl_data is read just before each rising edge.
    task automatic host_pulses(input int n, input int half);
        for (int k = 0; k < n; k++) begin
            hctrl_clk_in = 1'b0;
            cyc(half);
            rd[rd_n] = hctrl_data;
            rd_n++;
            hctrl_clk_in = 1'b1;
            cyc(half);
        end
        hctrl_clk_in = 1'b0;
        cyc(half);
    endtask

    task automatic test_reset;
        bit bad_d, bad_a, bad_s;
        cyc(3);
        n_cmp++;
        if (hctrl_data !== 1'b1) begin n_bad++; $display("FAIL reset_data got %b want 1", hctrl_data); end
        n_cmp++;
        if (host_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b want 0", host_active); end
        n_cmp++;
        if (frame_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b want 0", frame_strobe); end
        reset_n = 1'b1;
        bad_d = 0; bad_a = 0; bad_s = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (hctrl_data !== 1'b1) bad_d = 1;
            if (host_active !== 1'b0) bad_a = 1;
            if (frame_strobe !== 1'b0) bad_s = 1;
        end
        n_cmp++;
        if (bad_d) begin n_bad++; $display("FAIL idle_data got not-always-1 want 1"); end
        n_cmp++;
        if (bad_a) begin n_bad++; $display("FAIL idle_active got 1 want 0"); end
        n_cmp++;
        if (bad_s) begin n_bad++; $display("FAIL idle_strobe got 1 want 0"); end
    endtask

    task automatic test_basic_frame;
        bit   seen;
        logic exp;
        hctrl2_data = 8'hA5;
        hctrl1_data = 8'h3C;
        host_load(16, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_bad++; $display("FAIL basic_strobe got %b want 1", seen); end
        rd_n = 0;
        host_pulses(20, 128);
        for (int k = 0; k < 20; k++) begin
            exp = (k < 16) ? model_word[15-k] : 1'b1;
            n_cmp++;
            if (rd[k] !== exp) begin n_bad++; $display("FAIL basic_bit%0d got %b want %b", k, rd[k], exp); end
        end
    endtask

    task automatic test_midframe_change;
        bit   seen;
        logic exp;
        hctrl2_data = 8'hA5;
        hctrl1_data = 8'h3C;
        host_load(16, seen);
        rd_n = 0;
        host_pulses(4, 64);
        hctrl1_data = 8'h00;
        host_pulses(16, 64);
        for (int k = 0; k < 20; k++) begin
            exp = (k < 16) ? model_word[15-k] : 1'b1;
            n_cmp++;
            if (rd[k] !== exp) begin n_bad++; $display("FAIL mid_bit%0d got %b want %b", k, rd[k], exp); end
        end
        host_load(16, seen);
        rd_n = 0;
        host_pulses(16, 64);
        for (int k = 0; k < 16; k++) begin
            exp = model_word[15-k];
            n_cmp++;
            if (rd[k] !== exp) begin n_bad++; $display("FAIL next_bit%0d got %b want %b", k, rd[k], exp); end
        end
    endtask

    task automatic test_clk_during_load;
        logic exp;
        hctrl2_data = 8'($urandom);
        hctrl1_data = 8'($urandom);
        hctrl_load_n_in = 1'b0;
        cyc(12);
        hctrl_clk_in = 1'b1;
        cyc(16);
        model_word = {hctrl2_data, hctrl1_data};
        hctrl_load_n_in = 1'b1;
        cyc(16);
        hctrl_clk_in = 1'b0;
        cyc(16);
        rd_n = 0;
        host_pulses(17, 16);
        for (int k = 0; k < 17; k++) begin
            exp = (k < 16) ? model_word[15-k] : 1'b1;
            n_cmp++;
            if (rd[k] !== exp) begin n_bad++; $display("FAIL ldclk_bit%0d got %b want %b", k, rd[k], exp); end
        end
    endtask

    task automatic test_random_frames;
        bit   seen;
        logic exp;
        int   half, len, n;
        for (int f = 0; f < 8; f++) begin
            hctrl2_data = 8'($urandom);
            hctrl1_data = 8'($urandom);
            half = $urandom_range(MIN_HALF + 2, 40);
            len  = $urandom_range(MIN_HALF + 2, 30);
            n    = $urandom_range(16, 20);
            host_load(len, seen);
            n_cmp++;
            if (seen !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_strobe got %b want 1", f, seen); end
            hctrl2_data = 8'($urandom);
            hctrl1_data = 8'($urandom);
            rd_n = 0;
            host_pulses(n, half);
            for (int k = 0; k < n; k++) begin
                exp = (k < 16) ? model_word[15-k] : 1'b1;
                n_cmp++;
                if (rd[k] !== exp) begin
                    n_bad++;
                    $display("FAIL rnd%0d_bit%0d got %b want %b", f, k, rd[k], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit   seen;
        logic exp;
        for (int f = 0; f < 2; f++) begin
            hctrl2_data = 8'($urandom);
            hctrl1_data = 8'($urandom);
            host_load(MIN_HALF, seen);
            rd_n = 0;
            host_pulses(16, MIN_HALF);
            for (int k = 0; k < 16; k++) begin
                exp = model_word[15-k];
                n_cmp++;
                if (rd[k] !== exp) begin
                    n_bad++;
                    $display("FAIL b2b%0d_bit%0d got %b want %b", f, k, rd[k], exp);
                end
            end
        end
    endtask

    task automatic test_timeout;
        bit   seen;
        logic prev_act;
        cyc(300);
        n_cmp++;
        if (host_active !== 1'b0) begin n_bad++; $display("FAIL to_idle got %b want 0", host_active); end
        for (int r = 0; r < 2; r++) begin
            hctrl_load_n_in = 1'b0;
            cyc(10);
            hctrl_load_n_in = 1'b1;
            seen = 1'b0;
            prev_act = host_active;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (frame_strobe === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                prev_act = host_active;
            end
            n_cmp++;
            if (seen !== 1'b1) begin n_bad++; $display("FAIL to%0d_strobe got %b want 1", r, seen); end
            n_cmp++;
            if (prev_act !== 1'b0) begin n_bad++; $display("FAIL to%0d_pre_active got %b want 0", r, prev_act); end
            n_cmp++;
            if (host_active !== 1'b1) begin n_bad++; $display("FAIL to%0d_rise got %b want 1", r, host_active); end
            for (int k = 1; k <= 260; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_cmp++;
                    if (frame_strobe !== 1'b0) begin n_bad++; $display("FAIL to%0d_strobe_width got %b want 0", r, frame_strobe); end
                end
                if (k == 254) begin
                    n_cmp++;
                    if (host_active !== 1'b1) begin n_bad++; $display("FAIL to%0d_c254 got %b want 1", r, host_active); end
                end
                if (k == 255) begin
                    n_cmp++;
                    if (host_active !== 1'b0) begin n_bad++; $display("FAIL to%0d_c255 got %b want 0", r, host_active); end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midframe;
        bit seen, bad_s, bad_d;
        hctrl2_data = 8'h00;
        hctrl1_data = 8'hFF;
        host_load(16, seen);
        rd_n = 0;
        host_pulses(5, 16);
        n_cmp++;
        if (hctrl_data !== 1'b0) begin n_bad++; $display("FAIL rstmid_pre_data got %b want 0", hctrl_data); end
        n_cmp++;
        if (host_active !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_active got %b want 1", host_active); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (hctrl_data !== 1'b1) begin n_bad++; $display("FAIL rstmid_data got %b want 1", hctrl_data); end
        n_cmp++;
        if (host_active !== 1'b0) begin n_bad++; $display("FAIL rstmid_active got %b want 0", host_active); end
        cyc(3);
        reset_n = 1'b1;
        bad_s = 0; bad_d = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (frame_strobe !== 1'b0) bad_s = 1;
            if (hctrl_data !== 1'b1) bad_d = 1;
        end
        n_cmp++;
        if (bad_s) begin n_bad++; $display("FAIL rstrel_strobe got 1 want 0"); end
        n_cmp++;
        if (bad_d) begin n_bad++; $display("FAIL rstrel_data got 0 want 1"); end
    endtask

`ifdef HCTRL_GLITCH_FILTER_EN
    task automatic test_glitch;
        bit seen;
        hctrl2_data = 8'h7F;
        hctrl1_data = 8'hFF;
        host_load(16, seen);
        cyc(10);
        n_cmp++;
        if (hctrl_data !== 1'b0) begin n_bad++; $display("FAIL glitch_pre got %b want 0", hctrl_data); end
        hctrl_clk_in = 1'b1;
        cyc(2);
        hctrl_clk_in = 1'b0;
        cyc(30);
        n_cmp++;
        if (hctrl_data !== 1'b0) begin n_bad++; $display("FAIL glitch_noshift got %b want 0", hctrl_data); end
        rd_n = 0;
        host_pulses(1, MIN_HALF);
        cyc(5);
        n_cmp++;
        if (hctrl_data !== 1'b1) begin n_bad++; $display("FAIL glitch_realshift got %b want 1", hctrl_data); end
    endtask
`endif

    initial begin
        #3ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        hctrl_clk_in    = 1'b0;
        hctrl_load_n_in = 1'b1;
        hctrl1_data     = 8'hFF;
        hctrl2_data     = 8'hFF;
        rd_n            = 0;
        model_word      = 16'hFFFF;
        test_reset();
        test_basic_frame();
        test_midframe_change();
        test_clk_during_load();
        test_random_frames();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
`ifdef HCTRL_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
